// File: rtl/airlock_if.sv
// Airlock sequencer signal bundle: door requests, sensors,
// pump status and the controller's command outputs.
interface airlock_if;
  logic req_Inner;
  logic req_Outer;
  logic InnerClosed;
  logic OuterClosed;
  logic Evacuated;
  logic Pressurized;
  logic begin_Evacuation;
  logic begin_Pressurize;
  logic open_Inner;
  logic open_Outer;
  logic busy;
  logic fault;

  modport master (
    input  req_Inner, req_Outer,
    input  InnerClosed, OuterClosed,
    input  Evacuated, Pressurized,
    output begin_Evacuation, begin_Pressurize,
    output open_Inner, open_Outer,
    output busy, fault
  );

  modport slave (
    output req_Inner, req_Outer,
    output InnerClosed, OuterClosed,
    output Evacuated, Pressurized,
    input  begin_Evacuation, begin_Pressurize,
    input  open_Inner, open_Outer,
    input  busy, fault
  );
endinterface

// File: rtl/airlock_sequencer.sv
// Airlock controller: arbitrates door requests and sequences
// the pumps so a door only opens into matching pressure.
module airlock_sequencer #(
  parameter int DOOR_CYCLES   = 4,
  parameter int PUMP_TIMEOUT  = 16,
  parameter int CLOSE_TIMEOUT = 16,
  parameter int CNT_W         = 5
) (
  input  logic      Clock,
  input  logic      Reset,
  airlock_if.master bus
);

  typedef enum logic [2:0] {
    IDLE, OPEN_IN, OPEN_OUT, CLOSE_WAIT,
    EVAC, PRESS, FAULT
  } state_t;

  localparam logic [CNT_W-1:0] DOOR_LAST =
    CNT_W'(DOOR_CYCLES - 1);
  localparam logic [CNT_W-1:0] PUMP_LAST =
    CNT_W'(PUMP_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CLOSE_LAST =
    CNT_W'(CLOSE_TIMEOUT - 1);

  state_t           state;
  state_t           nxt;
  logic [CNT_W-1:0] cnt;
  logic             at_vac;
  logic             pend_in;
  logic             pend_out;
  logic             closed;
  logic             eff_in;
  logic             eff_out;
  logic             evac_q;
  logic             press_q;
  logic             open_in_q;
  logic             open_out_q;
  logic             busy_q;
  logic             fault_q;

  assign closed  = bus.InnerClosed & bus.OuterClosed;
  assign eff_in  = pend_in  | bus.req_Inner;
  assign eff_out = pend_out | bus.req_Outer;

  // Requests needing no pump cycle take priority.
  always_comb begin
    nxt = state;
    case (state)
      IDLE: begin
        if (eff_in && !at_vac && closed)
          nxt = OPEN_IN;
        else if (eff_out && at_vac && closed)
          nxt = OPEN_OUT;
        else if (eff_out && !at_vac && closed)
          nxt = EVAC;
        else if (eff_in && at_vac && closed)
          nxt = PRESS;
      end
      OPEN_IN, OPEN_OUT: begin
        if (cnt == DOOR_LAST)
          nxt = CLOSE_WAIT;
      end
      CLOSE_WAIT: begin
        if (closed)
          nxt = IDLE;
        else if (cnt == CLOSE_LAST)
          nxt = FAULT;
      end
      EVAC: begin
        if (!closed)
          nxt = FAULT;
        else if (bus.Evacuated)
          nxt = IDLE;
        else if (cnt == PUMP_LAST)
          nxt = FAULT;
      end
      PRESS: begin
        if (!closed)
          nxt = FAULT;
        else if (bus.Pressurized)
          nxt = IDLE;
        else if (cnt == PUMP_LAST)
          nxt = FAULT;
      end
      FAULT:   nxt = FAULT;
      default: nxt = FAULT;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state      <= IDLE;
      cnt        <= '0;
      at_vac     <= 1'b0;
      pend_in    <= 1'b0;
      pend_out   <= 1'b0;
      evac_q     <= 1'b0;
      press_q    <= 1'b0;
      open_in_q  <= 1'b0;
      open_out_q <= 1'b0;
      busy_q     <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      state <= nxt;
      if (nxt != state)
        cnt <= '0;
      else if (cnt != '1)
        cnt <= cnt + 1'b1;
      if (state == EVAC && nxt == IDLE)
        at_vac <= 1'b1;
      else if (state == PRESS && nxt == IDLE)
        at_vac <= 1'b0;
      // Entry clear beats a same-cycle set.
      if (nxt == OPEN_IN && state != OPEN_IN)
        pend_in <= 1'b0;
      else if (bus.req_Inner && state != OPEN_IN
               && state != FAULT)
        pend_in <= 1'b1;
      if (nxt == OPEN_OUT && state != OPEN_OUT)
        pend_out <= 1'b0;
      else if (bus.req_Outer && state != OPEN_OUT
               && state != FAULT)
        pend_out <= 1'b1;
      evac_q     <= (nxt == EVAC);
      press_q    <= (nxt == PRESS);
      open_in_q  <= (nxt == OPEN_IN);
      open_out_q <= (nxt == OPEN_OUT);
      busy_q     <= (nxt != IDLE);
      fault_q    <= (nxt == FAULT);
    end
  end

  assign bus.begin_Evacuation = evac_q;
  assign bus.begin_Pressurize = press_q;
  assign bus.open_Inner       = open_in_q;
  assign bus.open_Outer       = open_out_q;
  assign bus.busy             = busy_q;
  assign bus.fault            = fault_q;

endmodule

// File: tb/tb_airlock_sequencer.sv
// Scoreboard bench for airlock_sequencer: directed vectors push
// hand-computed outputs; a negedge monitor pops and compares.
module tb_airlock_sequencer;

  logic clk;
  logic rst_n;

  airlock_if bus ();

  airlock_sequencer #(
    .DOOR_CYCLES  (4),
    .PUMP_TIMEOUT (16),
    .CLOSE_TIMEOUT(16),
    .CNT_W        (5)
  ) dut (
    .Clock(clk),
    .Reset(rst_n),
    .bus  (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {rst_n, req_in, req_out, in_closed, out_closed, evac, press}
  localparam logic [6:0] N      = 7'b1001100;
  localparam logic [6:0] RI     = 7'b1101100;
  localparam logic [6:0] RO     = 7'b1011100;
  localparam logic [6:0] RB     = 7'b1111100;
  localparam logic [6:0] EVD    = 7'b1001110;
  localparam logic [6:0] PRD    = 7'b1001101;
  localparam logic [6:0] RST    = 7'b0001100;
  localparam logic [6:0] ICO    = 7'b1000100;
  localparam logic [6:0] RI_ICO = 7'b1100100;
  localparam logic [6:0] OCO_EV = 7'b1001010;

  // {begin_evac, begin_press, open_in, open_out, busy, fault}
  localparam logic [5:0] E_ID = 6'b000000;
  localparam logic [5:0] E_EV = 6'b100010;
  localparam logic [5:0] E_PR = 6'b010010;
  localparam logic [5:0] E_OI = 6'b001010;
  localparam logic [5:0] E_OO = 6'b000110;
  localparam logic [5:0] E_CW = 6'b000010;
  localparam logic [5:0] E_FT = 6'b000011;

  typedef struct {
    logic [5:0] exp;
    int         id;
  } exp_t;

  exp_t q[$];
  int   step;
  int   compared;
  int   mismatched;

  task automatic cyc(input logic [6:0] v,
                     input logic [5:0] e);
    exp_t x;
    rst_n           = v[6];
    bus.req_Inner   = v[5];
    bus.req_Outer   = v[4];
    bus.InnerClosed = v[3];
    bus.OuterClosed = v[2];
    bus.Evacuated   = v[1];
    bus.Pressurized = v[0];
    x.exp = e;
    x.id  = step;
    q.push_back(x);
    step++;
    @(posedge clk);
    #1;
  endtask

  // Remaining door-hold cycles, close wait, back to idle.
  task automatic serve(input logic [5:0] e);
    repeat (3) cyc(N, e);
    cyc(N, E_CW);
    cyc(N, E_ID);
  endtask

  always @(negedge clk) begin
    logic [5:0] got;
    exp_t       x;
    if (q.size() > 0) begin
      x   = q.pop_front();
      got = {bus.begin_Evacuation, bus.begin_Pressurize,
             bus.open_Inner, bus.open_Outer,
             bus.busy, bus.fault};
      compared++;
      if (got !== x.exp) begin
        mismatched++;
        $display("FAIL step%0d outputs: got %b expected %b",
                 x.id, got, x.exp);
      end
    end
  end

  initial begin
    step       = 0;
    compared   = 0;
    mismatched = 0;

    cyc(RST, E_ID);
    cyc(RST, E_ID);
    repeat (3) cyc(N, E_ID);

    // single inner request, late door close
    cyc(RI, E_OI);
    repeat (3) cyc(N, E_OI);
    cyc(ICO, E_CW);
    cyc(ICO, E_CW);
    cyc(N, E_ID);

    // outer request through evacuation, then back
    cyc(RO, E_EV);
    cyc(N, E_EV);
    cyc(EVD, E_ID);
    cyc(N, E_OO);
    serve(E_OO);
    cyc(RI, E_PR);
    cyc(N, E_PR);
    cyc(PRD, E_ID);
    cyc(N, E_OI);
    serve(E_OI);

    // simultaneous requests: inner first, outer kept
    cyc(RB, E_OI);
    serve(E_OI);
    cyc(N, E_EV);
    cyc(EVD, E_ID);
    cyc(N, E_OO);
    serve(E_OO);

    // request blocked by an open door, served later
    cyc(RI_ICO, E_ID);
    cyc(N, E_PR);
    cyc(PRD, E_ID);
    cyc(N, E_OI);
    serve(E_OI);

    // pump timeout; fault ignores requests until reset
    cyc(RO, E_EV);
    repeat (15) cyc(N, E_EV);
    cyc(N, E_FT);
    cyc(RI, E_FT);
    cyc(RI, E_FT);
    cyc(N, E_FT);
    cyc(RST, E_ID);
    cyc(N, E_ID);

    // door opens during evacuation
    cyc(RO, E_EV);
    cyc(N, E_EV);
    cyc(ICO, E_FT);
    cyc(RST, E_ID);

    // door open beats evacuated in the same cycle
    cyc(RO, E_EV);
    cyc(OCO_EV, E_FT);
    cyc(RST, E_ID);

    // reset mid-press returns to pressurized idle
    cyc(RO, E_EV);
    cyc(EVD, E_ID);
    cyc(N, E_OO);
    serve(E_OO);
    cyc(RI, E_PR);
    cyc(N, E_PR);
    cyc(RST, E_ID);
    cyc(RI, E_OI);
    serve(E_OI);

    // close timeout
    cyc(RI, E_OI);
    repeat (3) cyc(N, E_OI);
    cyc(ICO, E_CW);
    repeat (15) cyc(ICO, E_CW);
    cyc(ICO, E_FT);
    cyc(RST, E_ID);

    @(negedge clk);
    #1;
    if (q.size() != 0) begin
      mismatched++;
      $display("FAIL drain: got %0d pending expected 0",
               q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
